// File: rtl/fejkon_pcie_mm_sequencer.sv
// Bridges PCIe memory requests onto a single 32-bit Avalon-MM master, one transaction at a time.
// Reads produce a completion (with timeout fallback); writes are posted.
module fejkon_pcie_mm_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ADDR_MASK      = 32'h0000_FFFF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] mem_access_req_data,
  input  logic         mem_access_req_valid,
  output logic         mem_access_req_ready,
  output logic [127:0] mem_access_resp_data,
  output logic         mem_access_resp_valid,
  input  logic         mem_access_resp_ready,
  output logic [31:0]  mm_address,
  output logic [3:0]   mm_byteenable,
  output logic         mm_read,
  output logic         mm_write,
  output logic [31:0]  mm_writedata,
  input  logic [31:0]  mm_readdata,
  input  logic         mm_readdatavalid,
  input  logic         mm_waitrequest,
  input  logic [1:0]   mm_response
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic        ready_q;
  logic        accept;
  logic [15:0] id_q;
  logic [7:0]  tag_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic unused_req_bits;
  assign unused_req_bits = ^{mem_access_req_data[127:100], mem_access_req_data[63],
                             mem_access_req_data[32]};

  // ready is registered so that it reads 0 during reset even though state is IDLE
  assign mem_access_req_ready = ready_q;

  always_comb begin
    state_n               = state;
    accept                = 1'b0;
    mem_access_resp_valid = 1'b0;
    mem_access_resp_data  = '0;
    mm_read               = 1'b0;
    mm_write              = 1'b0;
    mm_address            = '0;
    mm_byteenable         = '0;
    mm_writedata          = '0;
    case (state)
      IDLE: begin
        if (mem_access_req_valid && ready_q) begin
          accept  = 1'b1;
          state_n = mem_access_req_data[0] ? WR_CMD : RD_CMD;
        end
      end
      RD_CMD: begin
        mm_read       = 1'b1;
        mm_address    = {addr_q, 2'b00} & ADDR_MASK;
        mm_byteenable = be_q;
        if (!mm_waitrequest) state_n = mm_readdatavalid ? RESP : RD_WAIT;
      end
      RD_WAIT: begin
        if (mm_readdatavalid || cnt_q == CNT_LAST) state_n = RESP;
      end
      WR_CMD: begin
        mm_write      = 1'b1;
        mm_address    = {addr_q, 2'b00} & ADDR_MASK;
        mm_byteenable = be_q;
        mm_writedata  = wdata_q;
        if (!mm_waitrequest) state_n = IDLE;
      end
      RESP: begin
        mem_access_resp_valid = 1'b1;
        mem_access_resp_data  = {63'b0, err_q, rdata_q, 3'b000, addr_q[4:0], tag_q, id_q};
        if (mem_access_resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      id_q    <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == IDLE);
      if (accept) begin
        id_q    <= mem_access_req_data[16:1];
        tag_q   <= mem_access_req_data[24:17];
        addr_q  <= mem_access_req_data[62:33];
        wdata_q <= mem_access_req_data[95:64];
        be_q    <= mem_access_req_data[0] ? mem_access_req_data[99:96] : 4'hF;
      end
      case (state)
        RD_CMD: begin
          if (!mm_waitrequest) begin
            cnt_q <= '0;
            if (mm_readdatavalid) begin
              rdata_q <= mm_readdata;
              err_q   <= (mm_response != 2'b00);
            end
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // returned data takes priority over a timeout landing in the same cycle
          if (mm_readdatavalid) begin
            rdata_q <= mm_readdata;
            err_q   <= (mm_response != 2'b00);
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fejkon_pcie_mm_sequencer.sv
// Directed + randomized bench for fejkon_pcie_mm_sequencer; expected values come from
// field-level request/completion arithmetic and per-transaction cycle budgets.
module tb_fejkon_pcie_mm_sequencer;

  localparam int unsigned T    = 8;
  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic         clk;
  logic         reset_n;
  logic [127:0] req_data;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] resp_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  mm_address;
  logic [3:0]   mm_byteenable;
  logic         mm_read;
  logic         mm_write;
  logic [31:0]  mm_writedata;
  logic [31:0]  mm_readdata;
  logic         mm_readdatavalid;
  logic         mm_waitrequest;
  logic [1:0]   mm_response;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned cyc  = 0;

  fejkon_pcie_mm_sequencer #(.TIMEOUT_CYCLES(T), .ADDR_MASK(MASK)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .mem_access_req_data   (req_data),
    .mem_access_req_valid  (req_valid),
    .mem_access_req_ready  (req_ready),
    .mem_access_resp_data  (resp_data),
    .mem_access_resp_valid (resp_valid),
    .mem_access_resp_ready (resp_ready),
    .mm_address            (mm_address),
    .mm_byteenable         (mm_byteenable),
    .mm_read               (mm_read),
    .mm_write              (mm_write),
    .mm_writedata          (mm_writedata),
    .mm_readdata           (mm_readdata),
    .mm_readdatavalid      (mm_readdatavalid),
    .mm_waitrequest        (mm_waitrequest),
    .mm_response           (mm_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_req(input logic wr, input logic [15:0] id,
      input logic [7:0] tag, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [127:0] r;
    r        = {$urandom, $urandom, $urandom, $urandom};
    r[0]     = wr;
    r[16:1]  = id;
    r[24:17] = tag;
    r[62:33] = a[31:2];
    r[95:64] = wd;
    r[99:96] = be;
    return r;
  endfunction

  function automatic logic [127:0] exp_cpl(input logic [15:0] id, input logic [7:0] tag,
      input logic [31:0] a, input logic [31:0] d, input logic err);
    logic [127:0] r;
    r        = '0;
    r[15:0]  = id;
    r[23:16] = tag;
    r[28:24] = a[6:2];
    r[63:32] = d;
    r[64]    = err;
    return r;
  endfunction

  // Precondition and postcondition: positioned at a negedge with the DUT idle and ready.
  // rdv_at: 0 = data with the command acceptance, k = k-th wait cycle, > T = never.
  task automatic do_read(input logic [31:0] a, input logic [15:0] id, input logic [7:0] tag,
      input int unsigned wait_n, input int unsigned rdv_at, input logic [31:0] rdata,
      input logic [1:0] resp, input int unsigned rdy_delay);
    logic        timed_out;
    int unsigned nwait, t0;
    logic [31:0] ea, ed;
    logic        ee;
    logic [127:0] ec;
    timed_out = (rdv_at > T);
    nwait     = (rdv_at == 0) ? 0 : (timed_out ? T : rdv_at);
    ea        = {a[31:2], 2'b00} & MASK;
    ed        = timed_out ? 32'hFFFF_FFFF : rdata;
    ee        = timed_out ? 1'b1 : (resp != 2'b00);
    ec        = exp_cpl(id, tag, a, ed, ee);

    check("rd_idle_ready", 128'(req_ready), 128'(1));
    t0        = cyc;
    req_data  = mk_req(1'b0, id, tag, a, $urandom, 4'($urandom));
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c <= int'(wait_n); c++) begin
      check("rd_cmd_read", 128'(mm_read), 128'(1));
      check("rd_cmd_write", 128'(mm_write), 128'(0));
      check("rd_cmd_addr", 128'(mm_address), 128'(ea));
      check("rd_cmd_be", 128'(mm_byteenable), 128'(4'hF));
      check("rd_cmd_ready", 128'(req_ready), 128'(0));
      check("rd_cmd_rvalid", 128'(resp_valid), 128'(0));
      mm_waitrequest   = (c < int'(wait_n));
      mm_readdatavalid = (c == int'(wait_n)) && (rdv_at == 0);
      mm_readdata      = mm_readdatavalid ? rdata : $urandom;
      mm_response      = mm_readdatavalid ? resp : 2'($urandom);
      @(negedge clk);
    end
    mm_waitrequest   = 1'b0;
    mm_readdatavalid = 1'b0;
    for (int k = 1; k <= int'(nwait); k++) begin
      check("rd_wait_read", 128'(mm_read), 128'(0));
      check("rd_wait_rvalid", 128'(resp_valid), 128'(0));
      check("rd_wait_ready", 128'(req_ready), 128'(0));
      mm_readdatavalid = (k == int'(rdv_at));
      mm_readdata      = mm_readdatavalid ? rdata : $urandom;
      mm_response      = mm_readdatavalid ? resp : 2'($urandom);
      @(negedge clk);
    end
    mm_readdatavalid = 1'b0;
    for (int r = 0; r <= int'(rdy_delay); r++) begin
      check("resp_valid", 128'(resp_valid), 128'(1));
      check("resp_data", resp_data, ec);
      check("resp_ready_low", 128'(req_ready), 128'(0));
      check("resp_no_cmd", 128'({mm_read, mm_write}), 128'(0));
      // a competing request must be held off while the completion is pending
      req_valid  = 1'b1;
      req_data   = mk_req(1'b1, 16'($urandom), 8'($urandom), $urandom, $urandom, 4'($urandom));
      resp_ready = (r == int'(rdy_delay));
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("rd_done_rvalid", 128'(resp_valid), 128'(0));
    check("rd_done_ready", 128'(req_ready), 128'(1));
    check("rd_latency", 128'(cyc - t0), 128'(wait_n + nwait + rdy_delay + 3));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [15:0] id, input logic [7:0] tag,
      input logic [31:0] wd, input logic [3:0] be, input int unsigned wait_n);
    int unsigned t0;
    logic [31:0] ea;
    ea = {a[31:2], 2'b00} & MASK;
    check("wr_idle_ready", 128'(req_ready), 128'(1));
    t0        = cyc;
    req_data  = mk_req(1'b1, id, tag, a, wd, be);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c <= int'(wait_n); c++) begin
      check("wr_cmd_write", 128'(mm_write), 128'(1));
      check("wr_cmd_read", 128'(mm_read), 128'(0));
      check("wr_cmd_addr", 128'(mm_address), 128'(ea));
      check("wr_cmd_data", 128'(mm_writedata), 128'(wd));
      check("wr_cmd_be", 128'(mm_byteenable), 128'(be));
      check("wr_cmd_ready", 128'(req_ready), 128'(0));
      check("wr_cmd_rvalid", 128'(resp_valid), 128'(0));
      mm_waitrequest = (c < int'(wait_n));
      @(negedge clk);
    end
    mm_waitrequest = 1'b0;
    check("wr_done_write", 128'(mm_write), 128'(0));
    check("wr_done_rvalid", 128'(resp_valid), 128'(0));
    check("wr_done_ready", 128'(req_ready), 128'(1));
    check("wr_latency", 128'(cyc - t0), 128'(wait_n + 2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    check({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
    check({tag, "_resp_data"}, resp_data, 128'(0));
    check({tag, "_mm_cmd"}, 128'({mm_read, mm_write}), 128'(0));
    check({tag, "_mm_address"}, 128'(mm_address), 128'(0));
    check({tag, "_mm_be"}, 128'(mm_byteenable), 128'(0));
    check({tag, "_mm_wdata"}, 128'(mm_writedata), 128'(0));
  endtask

  initial begin
    reset_n          = 1'b0;
    req_data         = '0;
    req_valid        = 1'b0;
    resp_ready       = 1'b0;
    mm_readdata      = '0;
    mm_readdatavalid = 1'b0;
    mm_waitrequest   = 1'b0;
    mm_response      = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // directed cases
    do_read(32'h0000_0004, 16'h0100, 8'h2A, 0, 1, 32'hDEAD_BEEF, 2'b00, 0);
    do_write(32'h0000_0010, 16'h0200, 8'h11, 32'h1234_5678, 4'h3, 3);
    do_read(32'h0000_0020, 16'h0300, 8'h05, 0, T + 1, 32'h0, 2'b00, 0);
    do_read(32'h0000_007C, 16'h0400, 8'h77, 1, 2, 32'hCAFE_F00D, 2'b00, 5);
    do_read(32'h0000_0044, 16'h0500, 8'h3C, 0, 1, 32'h5555_AAAA, 2'b10, 0);
    do_read(32'h0000_0048, 16'h0600, 8'h3D, 2, 0, 32'h0BAD_CAFE, 2'b00, 1);
    do_read(32'h0000_004C, 16'h0700, 8'h3E, 0, T, 32'h7777_1111, 2'b01, 0);
    do_read(32'hABCD_1234, 16'hFFFF, 8'hFF, 0, 3, 32'h0123_4567, 2'b00, 0);
    do_write(32'hFFFF_FFFC, 16'h0800, 8'h01, 32'hA5A5_5A5A, 4'hC, 0);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_write($urandom, 16'($urandom), 8'($urandom), $urandom, 4'($urandom),
                 $urandom_range(0, 3));
      else
        do_read($urandom, 16'($urandom), 8'($urandom), $urandom_range(0, 3),
                $urandom_range(0, T + 2), $urandom, 2'($urandom), $urandom_range(0, 3));
    end

    // reset in the middle of a read, then a stray readdatavalid
    req_data  = mk_req(1'b0, 16'h0900, 8'h09, 32'h0000_0100, 32'h0, 4'h0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n          = 1'b1;
    mm_readdatavalid = 1'b1;
    mm_readdata      = 32'h1357_9BDF;
    @(negedge clk);
    mm_readdatavalid = 1'b0;
    check("late_rdv_ready", 128'(req_ready), 128'(1));
    for (int k = 0; k < 3; k++) begin
      resp_ready = 1'b1;
      check("late_rdv_no_resp", 128'(resp_valid), 128'(0));
      check("late_rdv_no_cmd", 128'({mm_read, mm_write}), 128'(0));
      @(negedge clk);
    end
    resp_ready = 1'b0;
    do_read(32'h0000_0008, 16'h0A00, 8'h0A, 0, 1, 32'h2468_ACE0, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
